// File: rtl/me_pkg.sv
// Shared types and width helpers for the motion-estimation SAD datapath.
// Also used by the AD array feeder, so the lane layout is defined only here.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // A counter over n values needs at least one bit even when n is 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Block SAD sums edge_len*edge_len addends of psad_w bits each.
    function automatic int sad_width(input int psad_w, input int edge_len);
        return psad_w + 2 * clog2(edge_len);
    endfunction

    function automatic int idx_width(input int pixels_in_batch, input int num_batches);
        return cnt_width(pixels_in_batch * num_batches);
    endfunction

    // LSB of the addend for (column, candidate) within a flattened batch word.
    function automatic int lane_lsb(input int col, input int cand,
                                    input int pixels_in_batch, input int psad_w);
        return (col * pixels_in_batch + cand) * psad_w;
    endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// Combinational N-input unsigned adder tree; operands are zero-extended to OUT_W.
// The parent registers the result, so the tree depth sets the S1 critical path.
module sad_adder_tree
    import me_pkg::*;
#(
    parameter int N     = 8,
    parameter int IN_W  = 11,
    parameter int OUT_W = 17
) (
    input  logic [N*IN_W-1:0] addends,
    output logic [OUT_W-1:0]  sum
);
    localparam int LEVELS = clog2(N);
    localparam int LEAVES = 1 << LEVELS;

    logic [OUT_W-1:0] level [LEAVES];

    // NOTE: blocking assignments inside always_comb; each tree level is reduced
    // in place, so later statements must see the values just written.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            level[i] = '0;
            if (i < N) begin
                level[i] = OUT_W'(addends[i*IN_W +: IN_W]);
            end
        end
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                level[i] = level[2*i] + level[2*i+1];
            end
        end
        sum = level[0];
    end

endmodule

// File: rtl/sad_min_collector.sv
// Completes per-candidate block SADs from column partial sums and tracks the
// minimum SAD and its global candidate index across one search window.
module sad_min_collector
    import me_pkg::*;
#(
    parameter int  PIXELS_IN_BATCH = 16,
    parameter int  EDGE_LEN        = 8,
    parameter int  PSAD_BIT_WIDTH  = 11,
    parameter int  NUM_BATCHES     = 16,
    localparam int SAD_WIDTH       = sad_width(PSAD_BIT_WIDTH, EDGE_LEN),
    localparam int IDX_WIDTH       = idx_width(PIXELS_IN_BATCH, NUM_BATCHES),
    localparam int BATCH_W         = PSAD_BIT_WIDTH * EDGE_LEN * PIXELS_IN_BATCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 search_start,
    input  logic                 psad_valid,
    input  logic [BATCH_W-1:0]   psad_addend_batch,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [IDX_WIDTH-1:0] best_index,
    output logic                 done
);
    localparam int ROW_W  = EDGE_LEN * PSAD_BIT_WIDTH;
    localparam int COL_W  = cnt_width(EDGE_LEN);
    localparam int BCNT_W = cnt_width(NUM_BATCHES);
    localparam int K_W    = cnt_width(PIXELS_IN_BATCH);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(EDGE_LEN - 1);
    localparam logic [BCNT_W-1:0] BATCH_LAST = BCNT_W'(NUM_BATCHES - 1);

    state_e                state_q, state_d;
    logic                  in_valid_q, in_valid_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s3_valid_q, s3_valid_d;
    logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
    logic [BCNT_W-1:0]     batch_cnt_q, batch_cnt_d;
    logic [SAD_WIDTH-1:0]  best_sad_q, best_sad_d;
    logic [IDX_WIDTH-1:0]  best_index_q, best_index_d;
    logic                  done_q, done_d;

    logic [BATCH_W-1:0]    in_batch_q, in_batch_d;
    logic [SAD_WIDTH-1:0]  tree_sum [PIXELS_IN_BATCH];
    logic [SAD_WIDTH-1:0]  s1_sum_q [PIXELS_IN_BATCH];
    logic [SAD_WIDTH-1:0]  s1_sum_d [PIXELS_IN_BATCH];
    logic [SAD_WIDTH-1:0]  acc_q    [PIXELS_IN_BATCH];
    logic [SAD_WIDTH-1:0]  acc_d    [PIXELS_IN_BATCH];
    logic [SAD_WIDTH-1:0]  bmin_sad_q, bmin_sad_d;
    logic [K_W-1:0]        bmin_k_q, bmin_k_d;

    // Regroup the lane-major input so each candidate's tree sees its EDGE_LEN columns.
    for (genvar k = 0; k < PIXELS_IN_BATCH; k++) begin : g_cand
        logic [ROW_W-1:0] col_addends;
        for (genvar c = 0; c < EDGE_LEN; c++) begin : g_col
            assign col_addends[c*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH] =
                in_batch_q[lane_lsb(c, k, PIXELS_IN_BATCH, PSAD_BIT_WIDTH) +: PSAD_BIT_WIDTH];
        end
        sad_adder_tree #(
            .N     (EDGE_LEN),
            .IN_W  (PSAD_BIT_WIDTH),
            .OUT_W (SAD_WIDTH)
        ) u_tree (
            .addends (col_addends),
            .sum     (tree_sum[k])
        );
    end

    // Datapath next-state: input capture, S1 sums, S2 accumulation, S3 batch min.
    // NOTE: every _d gets its hold value first, so no path through the block
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        in_batch_d = in_batch_q;
        if (psad_valid) begin
            in_batch_d = psad_addend_batch;
        end

        s1_sum_d = s1_sum_q;
        if (in_valid_q) begin
            s1_sum_d = tree_sum;
        end

        acc_d = acc_q;
        if (s1_valid_q) begin
            for (int k = 0; k < PIXELS_IN_BATCH; k++) begin
                acc_d[k] = (col_cnt_q == '0) ? s1_sum_q[k] : acc_q[k] + s1_sum_q[k];
            end
        end

        // Strict compare while scanning upward keeps the lowest k on ties.
        bmin_sad_d = bmin_sad_q;
        bmin_k_d   = bmin_k_q;
        if (s2_valid_q) begin
            bmin_sad_d = acc_q[0];
            bmin_k_d   = '0;
            for (int k = 1; k < PIXELS_IN_BATCH; k++) begin
                if (acc_q[k] < bmin_sad_d) begin
                    bmin_sad_d = acc_q[k];
                    bmin_k_d   = K_W'(k);
                end
            end
        end
    end

    // Control next-state: FSM, valid pipeline, counters and the global minimum.
    always_comb begin
        state_d      = state_q;
        in_valid_d   = psad_valid && (state_q == RUN);
        s1_valid_d   = in_valid_q;
        s2_valid_d   = 1'b0;
        s3_valid_d   = s2_valid_q;
        col_cnt_d    = col_cnt_q;
        batch_cnt_d  = batch_cnt_q;
        best_sad_d   = best_sad_q;
        best_index_d = best_index_q;
        done_d       = 1'b0;

        if (s1_valid_q && state_q == RUN) begin
            if (col_cnt_q == COL_LAST) begin
                s2_valid_d = 1'b1;
                col_cnt_d  = '0;
            end else begin
                col_cnt_d  = col_cnt_q + 1'b1;
            end
        end

        // Strict compare: a later batch that only ties keeps the earlier index.
        if (s3_valid_q && state_q == RUN) begin
            if (bmin_sad_q < best_sad_q) begin
                best_sad_d   = bmin_sad_q;
                best_index_d = IDX_WIDTH'(int'(batch_cnt_q) * PIXELS_IN_BATCH + int'(bmin_k_q));
            end
            if (batch_cnt_q == BATCH_LAST) begin
                batch_cnt_d = '0;
                done_d      = 1'b1;
                state_d     = DONE;
            end else begin
                batch_cnt_d = batch_cnt_q + 1'b1;
            end
        end

        // A new search flushes everything in flight; a beat arriving with the
        // pulse is kept as column 0 of batch 0.
        if (search_start) begin
            state_d      = RUN;
            in_valid_d   = psad_valid;
            s1_valid_d   = 1'b0;
            s2_valid_d   = 1'b0;
            s3_valid_d   = 1'b0;
            col_cnt_d    = '0;
            batch_cnt_d  = '0;
            best_sad_d   = '1;
            best_index_d = '0;
            done_d       = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_valid_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            col_cnt_q    <= '0;
            batch_cnt_q  <= '0;
            best_sad_q   <= '1;
            best_index_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_valid_q   <= in_valid_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s3_valid_q   <= s3_valid_d;
            col_cnt_q    <= col_cnt_d;
            batch_cnt_q  <= batch_cnt_d;
            best_sad_q   <= best_sad_d;
            best_index_q <= best_index_d;
            done_q       <= done_d;
        end
    end

    // NOTE: the wide datapath registers are deliberately left without reset;
    // every consumer is qualified by a valid bit that is reset.
    always_ff @(posedge clk) begin
        in_batch_q <= in_batch_d;
        s1_sum_q   <= s1_sum_d;
        acc_q      <= acc_d;
        bmin_sad_q <= bmin_sad_d;
        bmin_k_q   <= bmin_k_d;
    end

    assign best_sad   = best_sad_q;
    assign best_index = best_index_q;
    assign done       = done_q;

endmodule
